// File: rtl/spi_reg_pkg.sv
// spi_reg_mm shared definitions.
// Opcodes, FSM states and sclk edge selection.
package spi_reg_pkg;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_RSV  = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_FAST = 2'b11;

    typedef enum logic [1:0] {
        ST_WAIT_DESEL,
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

    // Maps the two synced sclk edges onto {sample, change}
    // for the mode latched at start of frame.
    function automatic logic [1:0] edge_sel(
        input logic cpol,
        input logic cpha,
        input logic rise,
        input logic fall
    );
        logic lead;
        logic trail;
        lead  = cpol ? fall : rise;
        trail = cpol ? rise : fall;
        return cpha ? {trail, lead} : {lead, trail};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_reg_mm pin synchroniser.
// Two sync flops, one history flop for edge pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    // sr[1:0] synchronise, sr[2] holds the previous synced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {3{RST_VAL}};
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    assign q    = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_reg_mm.sv
// spi_reg_mm: SPI register slave, four modes,
// bursts with wrap, read prefetch strobe, frame errors.
module spi_reg_mm
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int REG_W    = 8,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              nss,
    input  logic              mosi,
    output logic              miso,
    input  logic [7:0]        status,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rd_stb,
    input  logic [REG_W-1:0]  reg_data_i,
    output logic [REG_W-1:0]  reg_data_o,
    output logic              reg_wr_vld,
    output logic [5:0]        fastcmd,
    output logic              fastcmd_vld,
    output logic              frame_err
);

    localparam int CW = $clog2(REG_W);
    localparam logic [CW-1:0] CMD_LAST  = CW'(7);
    localparam logic [CW-1:0] WORD_LAST = CW'(REG_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST =
        ADDR_W'(NUM_REGS - 1);

    logic sclk_lvl_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic nss_q;
    logic eof;
    logic sof;
    logic mosi_q;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    state_t state;
    state_t state_nx;

    logic [1:0]       sync_rdy;
    logic             cpol_q;
    logic             cpha_q;
    logic             smp;
    logic             chg;
    logic [CW-1:0]    bit_cnt;
    logic             cnt_last;
    logic             active;
    logic [REG_W-2:0] isr;
    logic [REG_W-1:0] word_in;
    logic [REG_W-1:0] osr;
    logic [1:0]       cmd_op;
    logic             is_wr;
    logic             ld_pend;

    logic load_stat;
    logic cmd_done;
    logic word_done;
    logic err_nx;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .q    (sclk_lvl_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_nss (
        .clk  (clk),
        .rst  (rst),
        .din  (nss),
        .q    (nss_q),
        .rise (eof),
        .fall (sof)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (mosi),
        .q    (mosi_q),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    function automatic logic [ADDR_W-1:0] addr_next(
        input logic [ADDR_W-1:0] a
    );
        return (a == ADDR_LAST) ? '0 : a + 1'b1;
    endfunction

    assign {smp, chg} = edge_sel(cpol_q, cpha_q,
                                 sclk_rise, sclk_fall);
    assign word_in  = {isr, mosi_q};
    assign cmd_op   = word_in[7:6];
    assign active   = (state == ST_CMD) || (state == ST_DATA);
    assign cnt_last = (state == ST_CMD) ?
                      (bit_cnt == CMD_LAST) :
                      (bit_cnt == WORD_LAST);
    assign miso     = osr[REG_W-1];

    // Holds off frame detection until the nss sync flops
    // reflect the pin rather than their reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_rdy <= '0;
        end else begin
            sync_rdy <= {sync_rdy[0], 1'b1};
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_WAIT_DESEL;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-cycle control events
    always_comb begin
        state_nx  = state;
        load_stat = 1'b0;
        cmd_done  = 1'b0;
        word_done = 1'b0;
        err_nx    = 1'b0;
        unique case (state)
            ST_WAIT_DESEL: begin
                if (sync_rdy[1] && nss_q) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (sof) begin
                    state_nx  = ST_CMD;
                    load_stat = 1'b1;
                end
            end
            ST_CMD: begin
                if (eof) begin
                    state_nx = ST_IDLE;
                    err_nx   = (bit_cnt != '0);
                end else if (smp && cnt_last) begin
                    cmd_done = 1'b1;
                    case (cmd_op)
                        OP_FAST: state_nx = ST_WAIT_DESEL;
                        OP_RSV: begin
                            state_nx = ST_WAIT_DESEL;
                            err_nx   = 1'b1;
                        end
                        default: state_nx = ST_DATA;
                    endcase
                end
            end
            ST_DATA: begin
                if (eof) begin
                    state_nx = ST_IDLE;
                    err_nx   = (bit_cnt != '0);
                end else if (smp && cnt_last) begin
                    word_done = 1'b1;
                end
            end
            default: state_nx = ST_WAIT_DESEL;
        endcase
    end

    // Serial datapath: mode latch, bit counter, shifters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            bit_cnt <= '0;
            isr     <= '0;
            osr     <= '0;
        end else begin
            if (load_stat) begin
                cpol_q  <= cpol;
                cpha_q  <= cpha;
                bit_cnt <= '0;
                osr     <= REG_W'(status) << (REG_W - 8);
            end else if (active) begin
                if (smp) begin
                    isr     <= word_in[REG_W-2:0];
                    bit_cnt <= cnt_last ? '0 : bit_cnt + 1'b1;
                end
                if (chg && (bit_cnt != '0)) begin
                    osr <= {osr[REG_W-2:0], 1'b0};
                end
            end
            if (cmd_done && (cmd_op != OP_RD)) begin
                osr <= '0;
            end
            if (ld_pend) begin
                osr <= reg_data_i;
            end
        end
    end

    // Register-file side: address, strobes, write data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_addr    <= '0;
            reg_data_o  <= '0;
            reg_wr_vld  <= 1'b0;
            reg_rd_stb  <= 1'b0;
            fastcmd     <= '0;
            fastcmd_vld <= 1'b0;
            frame_err   <= 1'b0;
            ld_pend     <= 1'b0;
            is_wr       <= 1'b0;
        end else begin
            reg_wr_vld  <= 1'b0;
            reg_rd_stb  <= 1'b0;
            fastcmd_vld <= 1'b0;
            frame_err   <= err_nx;
            ld_pend     <= reg_rd_stb;
            if (reg_wr_vld) begin
                reg_addr <= addr_next(reg_addr);
            end
            if (cmd_done) begin
                reg_addr <= word_in[ADDR_W-1:0];
                is_wr    <= (cmd_op == OP_WR);
                if (cmd_op == OP_FAST) begin
                    fastcmd     <= word_in[5:0];
                    fastcmd_vld <= 1'b1;
                end
                if (cmd_op == OP_RD) begin
                    reg_rd_stb <= 1'b1;
                end
            end
            if (word_done) begin
                if (is_wr) begin
                    reg_data_o <= word_in;
                    reg_wr_vld <= 1'b1;
                end else begin
                    reg_addr   <= addr_next(reg_addr);
                    reg_rd_stb <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_mm.sv
// spi_reg_mm bench: 8-bit/6-reg and 16-bit/8-reg
// instances driven by one directed SPI master.
module tb_spi_reg_mm;

    localparam int HALF = 8;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic cpol = 1'b0;
    logic cpha = 1'b0;
    logic sclk = 1'b0;
    logic nss  = 1'b1;
    logic mosi = 1'b0;
    logic [7:0] status = 8'h5C;
    logic msel = 1'b0;
    logic clr  = 1'b1;

    logic       miso8;
    logic [2:0] a8;
    logic       u8_rd;
    logic [7:0] do8;
    logic       u8_wr;
    logic [5:0] fc8;
    logic       u8_fv;
    logic       u8_fe;

    logic        miso16;
    logic [2:0]  a16;
    logic        u16_rd;
    logic [15:0] di16 = 16'h0;
    logic [15:0] u16_do_unused;
    logic        u16_wr_unused;
    logic [5:0]  u16_fc_unused;
    logic        u16_fv_unused;
    logic        u16_fe_unused;

    logic        miso_m;
    logic [15:0] mem16 [0:7];

    int n_chk  = 0;
    int n_pass = 0;
    int n_wr8, n_rd8, n_fv8, n_fe8, n_rd16;
    logic [2:0] wa8 [0:7];
    logic [7:0] wd8 [0:7];
    logic [31:0] r;

    always #5 clk = ~clk;

    assign miso_m = msel ? miso16 : miso8;

    spi_reg_mm #(
        .ADDR_W(3), .REG_W(8), .NUM_REGS(6)
    ) u8 (
        .clk(clk), .rst(rst),
        .cpol(cpol), .cpha(cpha),
        .sclk(sclk), .nss(nss), .mosi(mosi),
        .miso(miso8), .status(status),
        .reg_addr(a8), .reg_rd_stb(u8_rd),
        .reg_data_i(8'h00), .reg_data_o(do8),
        .reg_wr_vld(u8_wr), .fastcmd(fc8),
        .fastcmd_vld(u8_fv), .frame_err(u8_fe)
    );

    spi_reg_mm #(
        .ADDR_W(3), .REG_W(16), .NUM_REGS(8)
    ) u16 (
        .clk(clk), .rst(rst),
        .cpol(cpol), .cpha(cpha),
        .sclk(sclk), .nss(nss), .mosi(mosi),
        .miso(miso16), .status(status),
        .reg_addr(a16), .reg_rd_stb(u16_rd),
        .reg_data_i(di16), .reg_data_o(u16_do_unused),
        .reg_wr_vld(u16_wr_unused),
        .fastcmd(u16_fc_unused),
        .fastcmd_vld(u16_fv_unused),
        .frame_err(u16_fe_unused)
    );

    // registered read source for the 16-bit instance
    always @(posedge clk) begin
        if (u16_rd) di16 <= mem16[a16];
    end

    // event counters and write log
    always @(posedge clk) begin
        if (clr) begin
            n_wr8  <= 0;
            n_rd8  <= 0;
            n_fv8  <= 0;
            n_fe8  <= 0;
            n_rd16 <= 0;
        end else begin
            if (u8_wr) begin
                wa8[n_wr8[2:0]] <= a8;
                wd8[n_wr8[2:0]] <= do8;
                n_wr8 <= n_wr8 + 1;
            end
            if (u8_rd)  n_rd8  <= n_rd8 + 1;
            if (u8_fv)  n_fv8  <= n_fv8 + 1;
            if (u8_fe)  n_fe8  <= n_fe8 + 1;
            if (u16_rd) n_rd16 <= n_rd16 + 1;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h",
                      tag, got, exp);
    endtask

    task automatic clear_cnt();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic frame_begin(input logic pol,
                               input logic pha);
        cpol = pol;
        cpha = pha;
        sclk = pol;
        repeat (2*HALF) @(negedge clk);
        nss = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (3*HALF) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [31:0] d,
                            input int n,
                            output logic [31:0] q);
        q = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = d[i];
                repeat (HALF) @(negedge clk);
                sclk = ~sclk;
                q = {q[30:0], miso_m};
                repeat (HALF) @(negedge clk);
                sclk = ~sclk;
            end else begin
                repeat (HALF) @(negedge clk);
                sclk = ~sclk;
                mosi = d[i];
                repeat (HALF) @(negedge clk);
                sclk = ~sclk;
                q = {q[30:0], miso_m};
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] ea [0:3];
        ea[0] = 3'd4; ea[1] = 3'd5;
        ea[2] = 3'd0; ea[3] = 3'd1;
        for (int i = 0; i < 8; i++) mem16[i] = 16'h0;
        mem16[2] = 16'h1234;
        mem16[3] = 16'hBEEF;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b0;
        chk("rst_addr",  32'(a8),    32'h0);
        chk("rst_wdata", 32'(do8),   32'h0);
        chk("rst_fcmd",  32'(fc8),   32'h0);
        chk("rst_miso",  32'(miso8), 32'h0);
        chk("rst_wr",    32'(u8_wr), 32'h0);
        chk("rst_ferr",  32'(u8_fe), 32'h0);

        // single write in each mode, status on miso
        msel = 1'b0;
        for (int m = 0; m < 4; m++) begin
            clear_cnt();
            frame_begin(m[1], m[0]);
            spi_bits(32'h83, 8, r);
            chk($sformatf("m%0d_status", m), r, 32'h5C);
            spi_bits(32'hA5, 8, r);
            frame_end();
            chk($sformatf("m%0d_nwr", m), n_wr8, 1);
            chk($sformatf("m%0d_addr", m),
                32'(wa8[0]), 32'h3);
            chk($sformatf("m%0d_data", m),
                32'(wd8[0]), 32'hA5);
        end

        // 16-bit read burst with prefetch, mode 3
        msel = 1'b1;
        clear_cnt();
        frame_begin(1'b1, 1'b1);
        spi_bits(32'h02, 8, r);
        spi_bits(32'h0, 16, r);
        chk("rd16_w0", r, 32'h1234);
        spi_bits(32'h0, 16, r);
        chk("rd16_w1", r, 32'hBEEF);
        frame_end();
        chk("rd16_nstb", n_rd16, 3);
        chk("rd16_addr", 32'(a16), 32'h4);

        // write burst wrapping at 6, mode 1
        msel = 1'b0;
        clear_cnt();
        frame_begin(1'b0, 1'b1);
        spi_bits(32'h84, 8, r);
        for (int w = 0; w < 4; w++) begin
            spi_bits(32'h11 * (w + 1), 8, r);
        end
        frame_end();
        chk("burst_nwr", n_wr8, 4);
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("burst_a%0d", w),
                32'(wa8[w]), 32'(ea[w]));
            chk($sformatf("burst_d%0d", w),
                32'(wd8[w]), 32'h11 * (w + 1));
        end

        // fast command with trailing bits, mode 2
        clear_cnt();
        frame_begin(1'b1, 1'b0);
        spi_bits(32'hC7, 8, r);
        spi_bits(32'hFF, 8, r);
        frame_end();
        chk("fast_code", 32'(fc8), 32'h07);
        chk("fast_nvld", n_fv8, 1);
        chk("fast_nwr",  n_wr8, 0);
        chk("fast_nerr", n_fe8, 0);

        // frame ends 5 bits into second word
        clear_cnt();
        frame_begin(1'b0, 1'b0);
        spi_bits(32'h81, 8, r);
        spi_bits(32'h5A, 8, r);
        spi_bits(32'h16, 5, r);
        frame_end();
        chk("part_nwr",  n_wr8, 1);
        chk("part_data", 32'(wd8[0]), 32'h5A);
        chk("part_nerr", n_fe8, 1);

        // reserved opcode
        clear_cnt();
        frame_begin(1'b0, 1'b0);
        spi_bits(32'h41, 8, r);
        frame_end();
        chk("rsv_nerr", n_fe8, 1);
        chk("rsv_nwr",  n_wr8, 0);
        chk("rsv_nrd",  n_rd8, 0);
        chk("rsv_nfv",  n_fv8, 0);

        // reset in mid-burst, released with nss low
        frame_begin(1'b0, 1'b0);
        spi_bits(32'h80, 8, r);
        spi_bits(32'h77, 8, r);
        spi_bits(32'h5, 3, r);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_addr",  32'(a8),  32'h0);
        chk("mrst_wdata", 32'(do8), 32'h0);
        rst = 1'b0;
        clear_cnt();
        spi_bits(32'hFF, 8, r);
        frame_end();
        chk("mrst_nwr",  n_wr8, 0);
        chk("mrst_nerr", n_fe8, 0);
        chk("mrst_nrd",  n_rd8, 0);
        chk("mrst_hold", 32'(a8), 32'h0);

        clear_cnt();
        frame_begin(1'b0, 1'b0);
        spi_bits(32'h82, 8, r);
        spi_bits(32'h3C, 8, r);
        frame_end();
        chk("post_nwr",  n_wr8, 1);
        chk("post_addr", 32'(wa8[0]), 32'h2);
        chk("post_data", 32'(wd8[0]), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
